// File: rtl/cpu_disk_clockgen_if.sv
// Bus between the DMA engine (master) and the CPU/disk block (slave):
// HOLD/ACK bus arbitration plus the disk word read/write port.
interface cpu_disk_clockgen_if;
  logic        HOLD;
  logic        ACK;
  logic        en_w;
  logic        en_r;
  logic [64:0] address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        addr_err;

  modport master (
    output HOLD, en_w, en_r, address, DataIn,
    input  ACK, DataOut, addr_err
  );

  modport slave (
    input  HOLD, en_w, en_r, address, DataIn,
    output ACK, DataOut, addr_err
  );
endinterface

// File: rtl/cpu_disk_clockgen.sv
// CPU/disk block: divide-by-2 clock, HOLD/ACK bus grant FSM with a CPU
// activity counter, and a DEPTH x 32 disk word store with a one-cycle
// registered read port and out-of-range detection.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | CPU owns the bus, cpu_count advances every cycle
// GRANTED | bus handed to the DMA engine, ACK high, cpu_count frozen
module cpu_disk_clockgen #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic             clk_out,
  output logic [CNT_W-1:0] cpu_count,
  cpu_disk_clockgen_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, GRANTED = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       dout_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              access;

  // Upper address bits must all be clear for the access to hit the store.
  assign idx      = bus.address[IDX_W-1:0];
  assign in_range = ~|bus.address[64:IDX_W];
  assign access   = bus.en_w | bus.en_r;

  assign bus.ACK      = (state_q == GRANTED);
  assign bus.DataOut  = dout_q;
  assign bus.addr_err = err_q;

  // Divide-by-2 output clock.
  always_ff @(posedge clock) begin
    if (reset) clk_out <= 1'b0;
    else       clk_out <= ~clk_out;
  end

  // Grant FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Grant FSM next state: follow HOLD one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.HOLD)  state_d = GRANTED;
      GRANTED: if (!bus.HOLD) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Activity counter uses the current (pre-transition) state.
  always_ff @(posedge clock) begin
    if (reset)                cpu_count <= '0;
    else if (state_q == RUN)  cpu_count <= cpu_count + CNT_W'(1);
  end

  // Disk store; reset preloads each word with its own index.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
    end else if (bus.en_w && in_range) begin
      mem[idx] <= bus.DataIn;
    end
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clock) begin
    if (reset)                      dout_q <= '0;
    else if (bus.en_r && in_range)  dout_q <= mem[idx];
  end

  // One-cycle error pulse for any access outside the store.
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= access && !in_range;
  end

endmodule

// File: tb/tb_cpu_disk_clockgen.sv
module tb_cpu_disk_clockgen;
  localparam int DEPTH = 256;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             clk_out;
  logic [CNT_W-1:0] cpu_count;

  cpu_disk_clockgen_if bus ();

  cpu_disk_clockgen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .clk_out   (clk_out),
    .cpu_count (cpu_count),
    .bus       (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edges since reset, grant = previous HOLD,
  // counter = cycles spent without grant, disk as a plain array.
  int               m_edges;
  logic             m_ack;
  logic [CNT_W-1:0] m_count;
  logic [31:0]      m_mem [DEPTH];
  logic [31:0]      m_dout;
  logic             m_err;

  typedef struct {
    logic        hold;
    logic        w;
    logic        r;
    logic [64:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit inr;
    int idx;
    if (reset) begin
      m_edges = 0;
      m_ack   = 1'b0;
      m_count = '0;
      m_dout  = '0;
      m_err   = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i);
    end else begin
      m_edges++;
      if (!m_ack) m_count = m_count + 1'b1;
      inr   = (bus.address < 65'(DEPTH));
      m_err = (bus.en_w || bus.en_r) && !inr;
      if (inr) begin
        idx = int'(bus.address[31:0]);
        if (bus.en_r) m_dout = m_mem[idx];
        if (bus.en_w) m_mem[idx] = bus.DataIn;
      end
      m_ack = bus.HOLD;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_out"},   64'(clk_out),      64'(m_edges % 2));
    chk({tag, ".ACK"},       64'(bus.ACK),      64'(m_ack));
    chk({tag, ".cpu_count"}, 64'(cpu_count),    64'(m_count));
    chk({tag, ".DataOut"},   64'(bus.DataOut),  64'(m_dout));
    chk({tag, ".addr_err"},  64'(bus.addr_err), 64'(m_err));
  endtask

  task automatic drive(input logic h, input logic w, input logic r,
                       input logic [64:0] a, input logic [31:0] d);
    bus.HOLD    = h;
    bus.en_w    = w;
    bus.en_r    = r;
    bus.address = a;
    bus.DataIn  = d;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);
    repeat (n) begin
      tick();
      check_all("reset");
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] frozen;
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);

    // Reset two cycles, then five free-running cycles.
    do_reset(2);
    chk("rst_clk_out", 64'(clk_out), 64'd0);
    chk("rst_count",   64'(cpu_count), 64'd0);
    chk("rst_dout",    64'(bus.DataOut), 64'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_all("run5");
      chk("run5_clk_seq", 64'(clk_out), 64'(c % 2));
    end
    chk("run5_count", 64'(cpu_count), 64'd5);
    chk("run5_ack",   64'(bus.ACK), 64'd0);

    // HOLD over edges 11..20, released at edge 21.
    do_reset(1);
    for (int c = 1; c <= 25; c++) begin
      drive((c >= 11 && c <= 20), 0, 0, '0, '0);
      tick();
      check_all("hold");
      if (c == 11) begin
        chk("hold_ack_rise", 64'(bus.ACK), 64'd1);
        chk("hold_cnt_11", 64'(cpu_count), 64'd11);
      end
      if (c == 20) chk("hold_cnt_frozen", 64'(cpu_count), 64'd11);
      if (c == 21) begin
        chk("hold_ack_fall", 64'(bus.ACK), 64'd0);
        chk("hold_cnt_21", 64'(cpu_count), 64'd11);
      end
      if (c == 22) chk("hold_cnt_resume", 64'(cpu_count), 64'd12);
    end

    // Counter wrap at 2^CNT_W.
    do_reset(1);
    drive(0, 0, 0, '0, '0);
    repeat ((1 << CNT_W) + 3) tick();
    check_all("wrap");
    chk("wrap_count", 64'(cpu_count), 64'd3);

    // Preloaded contents read back on consecutive cycles.
    do_reset(1);
    for (int a = 0; a < 20; a++) begin
      drive(0, 0, 1, 65'(a), '0);
      tick();
      check_all("preload");
      chk("preload_dout", 64'(bus.DataOut), 64'(a));
    end

    // Directed disk vectors.
    vt[0] = '{0, 1, 0, 65'd7,   32'hDEADBEEF, 32'd0,          0};
    vt[1] = '{0, 0, 1, 65'd7,   32'd0,        32'hDEADBEEF,   0};
    vt[2] = '{0, 1, 1, 65'd7,   32'd1,        32'hDEADBEEF,   0};
    vt[3] = '{0, 0, 1, 65'd7,   32'd0,        32'd1,          0};
    vt[4] = '{0, 1, 0, {1'b1, 64'd0}, 32'hFFFF, 32'd1,       1};
    vt[5] = '{0, 0, 0, 65'd0,   32'd0,        32'd1,          0};
    vt[6] = '{0, 0, 1, 65'd0,   32'd0,        32'd0,          0};
    vt[7] = '{0, 0, 1, 65'd256, 32'd0,        32'd0,          1};
    vt[8] = '{0, 0, 1, 65'd255, 32'd0,        32'd255,        0};
    vt[9] = '{1, 0, 1, 65'd3,   32'd0,        32'd3,          0};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].hold, vt[i].w, vt[i].r, vt[i].addr, vt[i].din);
      tick();
      check_all("vec");
      chk($sformatf("vec%0d_dout", i), 64'(bus.DataOut), 64'(vt[i].exp_dout));
      chk($sformatf("vec%0d_err", i),  64'(bus.addr_err), 64'(vt[i].exp_err));
    end

    // Reset while granted and reading.
    drive(1, 0, 1, 65'd5, '0);
    tick();
    tick();
    check_all("midgrant");
    chk("midgrant_ack", 64'(bus.ACK), 64'd1);
    frozen = bus.DataOut;
    chk("midgrant_dout", 64'(frozen), 64'd5);
    reset = 1'b1;
    tick();
    check_all("rst_mid");
    chk("rst_mid_ack",   64'(bus.ACK), 64'd0);
    chk("rst_mid_dout",  64'(bus.DataOut), 64'd0);
    chk("rst_mid_count", 64'(cpu_count), 64'd0);
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [64:0] a;
      a = 65'($urandom_range(DEPTH - 1, 0));
      case ($urandom_range(7, 0))
        0: a[64] = 1'b1;
        1: a[$urandom_range(63, 8)] = 1'b1;
        default: ;
      endcase
      reset = ($urandom_range(59, 0) == 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom);
      tick();
      check_all("rand");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_disk_clockgen.md
CPU_DISK_CLOCKGEN -- requirements
Module: cpu_disk_clockgen

Interface
REQ-001 SHALL provide parameter DEPTH, default 256: number of 32-bit disk words; power of two, at least 2.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the CPU activity counter.
REQ-003 SHALL provide port clock, input, 1 bit: the single system clock; every state element updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port clk_out, output, 1 bit: divide-by-2 clock generated from clock.
REQ-006 SHALL provide port HOLD, input, 1 bit: bus request from the DMA engine.
REQ-007 SHALL provide port ACK, output, 1 bit: CPU bus grant to the DMA engine.
REQ-008 SHALL provide port cpu_count, output, CNT_W bits: CPU activity counter.
REQ-009 SHALL provide port en_w, input, 1 bit: disk write enable.
REQ-010 SHALL provide port en_r, input, 1 bit: disk read enable.
REQ-011 SHALL provide port address, input, 65 bits: disk word address.
REQ-012 SHALL provide port DataIn, input, 32 bits: disk write data.
REQ-013 SHALL provide port DataOut, output, 32 bits: registered disk read data.
REQ-014 SHALL provide port addr_err, output, 1 bit: one-cycle pulse flagging an out-of-range disk access.

Function
REQ-015 Clock generator: clk_out SHALL toggle on every rising edge of clock while reset is low.
REQ-016 CPU state machine SHALL have exactly two states: RUN and GRANTED.
REQ-017 RUN with HOLD sampled 1 SHALL go to GRANTED on that edge, so ACK rises 1 cycle after HOLD.
REQ-018 GRANTED with HOLD sampled 0 SHALL go to RUN on that edge, so ACK falls 1 cycle after HOLD falls.
REQ-019 ACK SHALL be 1 exactly when the state is GRANTED (Moore output, no combinational path from HOLD).
REQ-020 In RUN, cpu_count SHALL increment by 1 every cycle and wrap modulo 2^CNT_W.
REQ-021 In GRANTED, cpu_count SHALL hold its value; the cycle in which the state changes SHALL use the old state's rule.
REQ-022 Disk index = address[log2(DEPTH)-1:0]; an access is in range iff all address bits above the index are 0.
REQ-023 In-range en_w SHALL write DataIn to mem[index] at the clock edge.
REQ-024 In-range en_r SHALL load DataOut with mem[index] at the clock edge, so read latency is 1 cycle.
REQ-025 With en_r low, DataOut SHALL hold its last value.
REQ-026 en_w and en_r both set, same in-range address: write SHALL occur and DataOut SHALL receive the pre-write (old) word.
REQ-027 Any en_w or en_r with an out-of-range address SHALL suppress the write, leave DataOut unchanged, and pulse addr_err high for that one cycle.
REQ-028 addr_err SHALL be 0 in every other cycle.
REQ-029 Disk accesses SHALL be independent of HOLD/ACK; the DMA engine alone sequences disk use.

Reset
REQ-030 While reset is high on an edge: clk_out=0, state=RUN, ACK=0, cpu_count=0, DataOut=0, addr_err=0.
REQ-031 Reset SHALL initialise mem[i] = i (zero-extended to 32 bits) for every i in 0..DEPTH-1.
REQ-032 Reset SHALL take priority over all other inputs, including mid-transfer and mid-grant (ACK drops on the reset edge).

Verification
REQ-033 Reset 2 cycles then run 5 cycles -> clk_out sequence 1,0,1,0,1; cpu_count = 5; ACK = 0.
REQ-034 HOLD=1 at cycle 10 -> ACK=1 from cycle 11 and cpu_count frozen; HOLD=0 at cycle 20 -> ACK=0 at cycle 21 and counting resumes.
REQ-035 After reset, en_r=1 for addresses 0..19 in consecutive cycles -> DataOut = 0..19, each one cycle after its address.
REQ-036 en_w=1, address=7, DataIn=32'hDEADBEEF, then en_r at 7 -> DataOut=32'hDEADBEEF; simultaneous en_w (DataIn=1) + en_r at 7 -> DataOut=32'hDEADBEEF, then a later read at 7 -> 1.
REQ-037 en_w=1 with address = 2^64 -> addr_err pulses 1 cycle, mem[0] still reads 0, DataOut unchanged.
REQ-038 Reset asserted while ACK=1 and en_r active -> next cycle ACK=0, DataOut=0, cpu_count=0.
